// File: rtl/tinyalu_arbiter.sv
// Round-robin arbiter that shares one TinyALU among NUM_REQ requesters.
// One operation in flight at a time; results come back tagged with the requester id.
module tinyalu_arbiter #(
  parameter  int NUM_REQ = 4,
  parameter  int TIMEOUT = 15,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [8*NUM_REQ-1:0] req_A,
  input  logic [8*NUM_REQ-1:0] req_B,
  input  logic [3*NUM_REQ-1:0] req_op,
  output logic                 rsp_valid,
  output logic [ID_W-1:0]      rsp_id,
  output logic [15:0]          rsp_result,
  output logic                 rsp_error,
  output logic [7:0]           alu_A,
  output logic [7:0]           alu_B,
  output logic [2:0]           alu_op,
  output logic                 alu_start,
  input  logic                 alu_done,
  input  logic [15:0]          alu_result
);

  // state | meaning
  // IDLE  | arbitrate among valid requesters, accept the winner
  // BUSY  | alu_start high, waiting for alu_done or timeout
  // RESP  | one-cycle response strobe, alu_start low
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [ID_W-1:0] r_ptr;
  logic [ID_W-1:0] r_id;
  logic [7:0]      r_a;
  logic [7:0]      r_b;
  logic [2:0]      r_op;
  logic [15:0]     r_result;
  logic            r_err;
  logic [7:0]      r_cnt;

  logic            w_found;
  logic [ID_W-1:0] w_winner;
  logic [ID_W-1:0] w_ptr_nxt;
  logic [7:0]      w_sel_a;
  logic [7:0]      w_sel_b;
  logic [2:0]      w_sel_op;
  logic            w_op_legal;
  logic [7:0]      w_cnt_inc;
  logic            w_tmo;

  // Search upward from r_ptr with wrap-around; first valid requester wins.
  always_comb begin : arb
    int              v_idx;
    logic [ID_W-1:0] v_id;
    v_idx    = 0;
    v_id     = '0;
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      v_idx = int'(r_ptr) + k;
      if (v_idx >= NUM_REQ) v_idx = v_idx - NUM_REQ;
      v_id = ID_W'(v_idx);
      if (!w_found && req_valid[v_id]) begin
        w_found  = 1'b1;
        w_winner = v_id;
      end
    end
  end

  always_comb begin : sel
    w_sel_a  = '0;
    w_sel_b  = '0;
    w_sel_op = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (ID_W'(k) == w_winner) begin
        w_sel_a  = req_A[8*k +: 8];
        w_sel_b  = req_B[8*k +: 8];
        w_sel_op = req_op[3*k +: 3];
      end
    end
  end

  assign w_op_legal = (w_sel_op >= 3'd1) && (w_sel_op <= 3'd4);
  assign w_ptr_nxt  = (w_winner == ID_W'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;
  assign w_cnt_inc  = r_cnt + 8'd1;
  assign w_tmo      = (w_cnt_inc == 8'(TIMEOUT));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // req_ready is gated by reset_n so every output reads 0 while reset is held.
  always_comb begin : fsm
    w_state_nxt = r_state;
    req_ready   = '0;
    alu_start   = 1'b0;
    alu_A       = '0;
    alu_B       = '0;
    alu_op      = '0;
    rsp_valid   = 1'b0;
    rsp_id      = '0;
    rsp_result  = '0;
    rsp_error   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          if (reset_n) req_ready[w_winner] = 1'b1;
          w_state_nxt = w_op_legal ? ST_BUSY : ST_RESP;
        end
      end
      ST_BUSY: begin
        alu_start = 1'b1;
        alu_A     = r_a;
        alu_B     = r_b;
        alu_op    = r_op;
        if (alu_done || w_tmo) w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid   = 1'b1;
        rsp_id      = r_id;
        rsp_result  = r_result;
        rsp_error   = r_err;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr    <= '0;
      r_id     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_a      <= w_sel_a;
            r_b      <= w_sel_b;
            r_op     <= w_sel_op;
            r_id     <= w_winner;
            r_ptr    <= w_ptr_nxt;
            r_cnt    <= '0;
            r_result <= '0;
            r_err    <= !w_op_legal;
          end
        end
        ST_BUSY: begin
          if (alu_done) begin
            r_result <= alu_result;
            r_err    <= 1'b0;
          end else begin
            r_cnt <= w_cnt_inc;
            if (w_tmo) begin
              r_result <= '0;
              r_err    <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tinyalu_arbiter.sv
// Scoreboard bench for tinyalu_arbiter with a behavioural TinyALU stand-in.
module tb_tinyalu_arbiter;
  localparam int NUM_REQ = 4;
  localparam int TIMEOUT = 15;
  localparam int ID_W    = $clog2(NUM_REQ);

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
  } cmd_t;

  typedef struct packed {
    int          id;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [2:0]  op;
    logic        legal;
    logic [15:0] res;
    logic        err;
    int          cyc;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b1;
  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [NUM_REQ-1:0]   req_ready;
  logic [8*NUM_REQ-1:0] req_A = '0;
  logic [8*NUM_REQ-1:0] req_B = '0;
  logic [3*NUM_REQ-1:0] req_op = '0;
  logic                 rsp_valid;
  logic [ID_W-1:0]      rsp_id;
  logic [15:0]          rsp_result;
  logic                 rsp_error;
  logic [7:0]           alu_A;
  logic [7:0]           alu_B;
  logic [2:0]           alu_op;
  logic                 alu_start;
  logic                 alu_done = 1'b0;
  logic [15:0]          alu_result = '0;

  cmd_t               cmd_q [NUM_REQ][$];
  cmd_t               drv_cmd [NUM_REQ];
  exp_t               sb [$];
  logic [NUM_REQ-1:0] drv_valid = '0;
  bit                 eager = 1'b1;
  bit                 allow_drop = 1'b0;
  bit                 hang = 1'b0;
  int                 m_ptr = 0;
  int                 m_free = 0;
  int                 cyc = 0;
  int                 n_chk = 0;
  int                 n_pass = 0;
  int                 grant_log [$];
  int                 run_len = 0;
  int                 last_run = 0;
  int                 start_runs = 0;
  int                 last_id = -1;
  logic [15:0]        last_res = '0;
  logic               last_err = 1'b0;

  tinyalu_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_A      (req_A),
    .req_B      (req_B),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_error  (rsp_error),
    .alu_A      (alu_A),
    .alu_B      (alu_B),
    .alu_op     (alu_op),
    .alu_start  (alu_start),
    .alu_done   (alu_done),
    .alu_result (alu_result)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
    if (cyc > 60000) begin
      $display("FAIL watchdog: cycle %0d exceeds limit 60000", cyc);
      $fatal(1, "bench did not terminate");
    end
  end

  function automatic logic [15:0] alu_fn(input logic [2:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
    case (op)
      3'd1:    return {8'h00, a} + {8'h00, b};
      3'd2:    return {8'h00, a & b};
      3'd3:    return {8'h00, a ^ b};
      3'd4:    return {8'h00, a} * {8'h00, b};
      default: return 16'h0000;
    endcase
  endfunction

  function automatic int lat_of(input logic [2:0] op);
    return (op == 3'd4) ? 3 : 1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_chk++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
  endtask

  task automatic drive_pins();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i]      = drv_valid[i];
      req_A[8*i +: 8]   = drv_cmd[i].a;
      req_B[8*i +: 8]   = drv_cmd[i].b;
      req_op[3*i +: 3]  = drv_cmd[i].op;
    end
  endtask

  task automatic push_cmd(input int i, input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] op);
    cmd_t c;
    c.a  = a;
    c.b  = b;
    c.op = op;
    cmd_q[i].push_back(c);
  endtask

  function automatic bit tb_busy();
    for (int i = 0; i < NUM_REQ; i++) if (cmd_q[i].size() != 0) return 1'b1;
    return (drv_valid != '0) || (sb.size() != 0);
  endfunction

  // One cycle: the reference model predicts the grant, then requesters react to ready.
  task automatic step();
    logic [NUM_REQ-1:0] g;
    exp_t               e;
    int                 w;
    @(negedge clk);
    g = req_ready;
    if (cyc >= m_free && drv_valid != '0) begin
      w = -1;
      for (int k = 0; k < NUM_REQ; k++) begin
        int j;
        j = (m_ptr + k) % NUM_REQ;
        if (w < 0 && drv_valid[j]) w = j;
      end
      e.id    = w;
      e.a     = drv_cmd[w].a;
      e.b     = drv_cmd[w].b;
      e.op    = drv_cmd[w].op;
      e.legal = (e.op >= 3'd1) && (e.op <= 3'd4);
      e.err   = !e.legal || hang;
      e.res   = e.err ? 16'h0000 : alu_fn(e.op, e.a, e.b);
      e.cyc   = cyc + (!e.legal ? 1 : ((hang ? TIMEOUT : lat_of(e.op)) + 1));
      sb.push_back(e);
      m_ptr  = (w + 1) % NUM_REQ;
      m_free = e.cyc + 1;
      chk("grant", 64'(g), 64'(1) << w);
    end else begin
      chk("no_grant", 64'(g), 64'd0);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (g[i] && drv_valid[i] && cmd_q[i].size() != 0) begin
        grant_log.push_back(i);
        void'(cmd_q[i].pop_front());
        drv_valid[i] = 1'b0;
      end
      if (!drv_valid[i] && cmd_q[i].size() != 0 && (eager || $urandom_range(0, 2) == 0)) begin
        drv_cmd[i]   = cmd_q[i][0];
        drv_valid[i] = 1'b1;
      end else if (drv_valid[i] && allow_drop && !g[i] && $urandom_range(0, 7) == 0) begin
        drv_valid[i] = 1'b0;
      end
    end
    drive_pins();
  endtask

  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    while (tb_busy() && n < budget) begin
      step();
      n++;
    end
    chk("drain_budget", 64'(tb_busy()), 64'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    sb.delete();
    for (int i = 0; i < NUM_REQ; i++) cmd_q[i].delete();
    drv_valid = '0;
    m_ptr     = 0;
    m_free    = 0;
    req_valid = '1;
    #1;
    chk("reset_outputs",
        64'({req_ready, rsp_valid, rsp_id, rsp_result, rsp_error, alu_A, alu_B, alu_op, alu_start}),
        64'd0);
    drive_pins();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // Response monitor: pops the scoreboard whenever rsp_valid is seen.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        chk("rsp_spurious", 64'(rsp_valid), 64'd0);
      end else begin
        e = sb.pop_front();
        chk("rsp_id", 64'(rsp_id), 64'(e.id));
        chk("rsp_result", 64'(rsp_result), 64'(e.res));
        chk("rsp_error", 64'(rsp_error), 64'(e.err));
        chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
        chk("start_low_in_rsp", 64'(alu_start), 64'd0);
        last_id  = int'(rsp_id);
        last_res = rsp_result;
        last_err = rsp_error;
      end
    end else if (sb.size() != 0 && sb[0].cyc < cyc) begin
      chk("rsp_missing", 64'(rsp_valid), 64'd1);
      void'(sb.pop_front());
    end
  end

  // TinyALU stand-in: single-cycle logic ops, 3-cycle mul, or never done when hang is set.
  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      alu_done   = 1'b0;
      alu_result = '0;
      if (run_len > 0) last_run = run_len;
      run_len = 0;
    end else begin
      alu_done   = 1'b0;
      alu_result = '0;
      if (alu_start) begin
        run_len++;
        if (run_len == 1) start_runs++;
        if (sb.size() == 0 || !sb[0].legal)
          chk("alu_start_unexpected", 64'(alu_start), 64'd0);
        else
          chk("alu_pins", 64'({alu_op, alu_A, alu_B}), 64'({sb[0].op, sb[0].a, sb[0].b}));
        if (!hang && run_len == lat_of(alu_op)) begin
          alu_done   = 1'b1;
          alu_result = alu_fn(alu_op, alu_A, alu_B);
        end
      end else begin
        chk("alu_idle_pins", 64'({alu_op, alu_A, alu_B}), 64'd0);
        if (run_len > 0) last_run = run_len;
        run_len = 0;
      end
    end
  end

  initial begin
    int runs_before;
    int n;
    int exp_g [6] = '{0, 1, 2, 3, 0, 1};
    for (int i = 0; i < NUM_REQ; i++) drv_cmd[i] = '0;
    #2;
    do_reset();

    push_cmd(0, 8'hFF, 8'h01, 3'b001);
    run_until_idle(50);
    chk("add_id", 64'(last_id), 64'd0);
    chk("add_result", 64'(last_res), 64'h0100);
    chk("add_error", 64'(last_err), 64'd0);

    push_cmd(3, 8'd200, 8'd200, 3'b100);
    run_until_idle(50);
    chk("mul_result", 64'(last_res), 64'h9C40);
    chk("mul_id", 64'(last_id), 64'd3);
    chk("mul_start_len", 64'(last_run), 64'd3);

    runs_before = start_runs;
    push_cmd(2, 8'hAA, 8'h55, 3'b110);
    run_until_idle(50);
    chk("illegal_no_start", 64'(start_runs), 64'(runs_before));
    chk("illegal_error", 64'(last_err), 64'd1);
    chk("illegal_result", 64'(last_res), 64'd0);
    chk("illegal_id", 64'(last_id), 64'd2);

    hang = 1'b1;
    push_cmd(1, 8'h12, 8'h34, 3'b001);
    run_until_idle(100);
    hang = 1'b0;
    chk("timeout_start_len", 64'(last_run), 64'(TIMEOUT));
    chk("timeout_error", 64'(last_err), 64'd1);
    chk("timeout_result", 64'(last_res), 64'd0);
    chk("timeout_id", 64'(last_id), 64'd1);
    push_cmd(0, 8'd3, 8'd4, 3'b001);
    run_until_idle(50);
    chk("after_timeout_result", 64'(last_res), 64'd7);

    push_cmd(2, 8'd200, 8'd200, 3'b100);
    n = 0;
    while (!alu_start && n < 20) begin
      step();
      n++;
    end
    @(negedge clk);
    #2;
    chk("busy_before_reset", 64'(alu_start), 64'd1);
    do_reset();
    grant_log.delete();
    push_cmd(1, 8'h21, 8'h43, 3'b011);
    push_cmd(0, 8'h0F, 8'h3C, 3'b010);
    run_until_idle(50);
    chk("post_reset_grants", 64'(grant_log.size()), 64'd2);
    if (grant_log.size() != 0) chk("post_reset_first_grant", 64'(grant_log[0]), 64'd0);

    do_reset();
    grant_log.delete();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NUM_REQ; i++)
        push_cmd(i, 8'($urandom), 8'($urandom), 3'b001);
    run_until_idle(100);
    chk("fair_grant_count", 64'(grant_log.size()), 64'd8);
    for (int k = 0; k < 6; k++)
      if (k < grant_log.size()) chk("fair_order", 64'(grant_log[k]), 64'(exp_g[k]));

    eager      = 1'b0;
    allow_drop = 1'b1;
    for (int k = 0; k < 150; k++)
      push_cmd($urandom_range(0, NUM_REQ - 1), 8'($urandom), 8'($urandom),
               ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(1, 4)));
    run_until_idle(5000);
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
